// File: rtl/mem_block_reader.sv
// Streams n = min(num_words, DEPTH) memory words in address order to a valid/ack consumer.
// First word is valid 3 cycles after accept, then 1 word/cycle; a 2-entry skid buffer absorbs ack stalls.
module mem_block_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_blockRead,
  input  logic [ADDR_W:0]   num_words,
  output logic              RDY_blockRead,
  output logic              DONE_blockRead,
  output logic              EN_readMem,
  output logic [ADDR_W-1:0] readMem_addr,
  input  logic [DATA_W-1:0] readMem_val,
  output logic              VALID_memVal,
  output logic [DATA_W-1:0] memVal_data,
  input  logic              ACK_memVal
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_n, r_issue;
  logic              r_inflight, r_zero_done;
  logic [DATA_W-1:0] r_buf0, r_buf1;
  logic [1:0]        r_cnt;
  logic [CW-1:0]     w_n_clamped;
  logic [2:0]        w_load;
  logic              w_accept, w_issue, w_pop, w_drained;

  assign w_n_clamped = (num_words > DEPTH_C) ? DEPTH_C : num_words;
  assign RDY_blockRead = (r_state == S_IDLE);
  assign w_accept      = RDY_blockRead && EN_blockRead;
  assign VALID_memVal  = (r_cnt != 2'd0);
  assign memVal_data   = r_buf0;
  assign w_pop         = VALID_memVal && ACK_memVal;

  // Slots committed after this cycle: buffered + word on the bus + this issue, minus a word leaving now.
  assign w_load     = {1'b0, r_cnt} + {2'b00, r_inflight} + 3'd1;
  assign w_issue    = (r_state == S_READ) && (w_load <= (3'd2 + {2'b00, w_pop}));
  assign EN_readMem   = w_issue;
  assign readMem_addr = r_issue[ADDR_W-1:0];

  assign w_drained      = (r_state == S_DRAIN) && (r_cnt == 2'd0) && !r_inflight;
  assign DONE_blockRead = w_drained || r_zero_done;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && (w_n_clamped != '0)) w_state_nxt = S_READ;
      S_READ:  if (w_issue && ((r_issue + ONE_C) == r_n)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_issue     <= '0;
      r_inflight  <= 1'b0;
      r_zero_done <= 1'b0;
      r_cnt       <= 2'd0;
      r_buf0      <= '0;
      r_buf1      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_inflight  <= w_issue;
      r_zero_done <= w_accept && (w_n_clamped == '0);
      if (w_accept) begin
        r_n     <= w_n_clamped;
        r_issue <= '0;
      end else if (w_issue) begin
        r_issue <= r_issue + ONE_C;
      end
      // Capture and pop in the same cycle keep occupancy; the head always holds the oldest word.
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= readMem_val;
          else               r_buf1 <= readMem_val;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf0 <= readMem_val;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= readMem_val;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_block_reader.sv
// Bench for mem_block_reader: directed blocks against a queue-based model of the word stream.
module tb_mem_block_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        EN_blockRead;
  logic [6:0]  num_words;
  logic        RDY_blockRead, DONE_blockRead, EN_readMem;
  logic [5:0]  readMem_addr;
  logic [31:0] readMem_val;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic        ACK_memVal;

  mem_block_reader #(.DATA_W(32), .ADDR_W(6), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .EN_blockRead(EN_blockRead), .num_words(num_words),
    .RDY_blockRead(RDY_blockRead), .DONE_blockRead(DONE_blockRead),
    .EN_readMem(EN_readMem), .readMem_addr(readMem_addr), .readMem_val(readMem_val),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .ACK_memVal(ACK_memVal)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | (32'(i) << 8) | 32'(255 - i);

  // Synchronous memory; poisoned data when not read so mistimed captures show up.
  always @(posedge clk) readMem_val <= EN_readMem ? mem[readMem_addr] : 32'hDEAD_BEEF;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state
  logic [31:0] expq[$];
  bit  active = 0, zero_pend = 0, prev_hold = 0, blk_done = 0;
  int  blk_n = 0, issued = 0, popped = 0, next_addr = 0, rel = 0;
  int  first_valid, last_valid, done_rel, rd_cnt, last_addr;
  logic [31:0] prev_dat, first_data, last_data;
  logic rdy_at_done;

  always @(negedge clk) begin : model_chk
    logic exp_done, rdy_exp, pop;
    int   nc;
    if (rst) begin
      active = 0; zero_pend = 0; prev_hold = 0; expq.delete();
    end else begin
      rel++;
      rdy_exp  = !active;
      exp_done = zero_pend || (active && popped == blk_n);
      chk("rdy", RDY_blockRead, rdy_exp);
      chk("done", DONE_blockRead, exp_done);
      if (DONE_blockRead) begin blk_done = 1; done_rel = rel; rdy_at_done = RDY_blockRead; end
      if (exp_done) begin zero_pend = 0; active = 0; end
      if (prev_hold) begin
        chk("hold_vld", VALID_memVal, 1'b1);
        chk("hold_dat", memVal_data, prev_dat);
      end
      if (VALID_memVal) begin
        chk("vld_has_word", expq.size() != 0, 1'b1);
        if (first_valid < 0) first_valid = rel;
        last_valid = rel;
      end
      if (EN_readMem) begin
        chk("rd_addr", readMem_addr, next_addr[5:0]);
        chk("rd_in_block", active && issued < blk_n, 1'b1);
        issued++; next_addr++; rd_cnt++; last_addr = readMem_addr;
      end
      pop = VALID_memVal && ACK_memVal;
      if (pop && expq.size() != 0) begin
        chk("data", memVal_data, expq.pop_front());
        if (popped == 0) first_data = memVal_data;
        last_data = memVal_data;
        popped++;
      end
      if (EN_readMem) chk("outstanding_le2", (issued - popped) <= 2, 1'b1);
      prev_hold = VALID_memVal && !ACK_memVal;
      prev_dat  = memVal_data;
      if (EN_blockRead && rdy_exp) begin
        nc = (num_words > 7'd64) ? 64 : int'(num_words);
        expq.delete();
        for (int i = 0; i < nc; i++) expq.push_back(mem[i]);
        blk_n = nc; issued = 0; popped = 0; next_addr = 0;
        active = (nc > 0); zero_pend = (nc == 0);
        rel = 0; first_valid = -1; last_valid = -1; done_rel = -1; rd_cnt = 0; last_addr = -1;
        first_data = 'x; last_data = 'x;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit ack_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Caller sits at the start of a cycle; that cycle becomes the accept cycle.
  task automatic run_block(input int n, input int ack_mode, input int repulse, input int budget);
    bit ok = 0;
    blk_done = 0;
    EN_blockRead = 1'b1; num_words = 7'(n); ACK_memVal = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (blk_done) begin ok = 1; break; end
      EN_blockRead = (k == repulse);
      num_words    = (k == repulse) ? 7'd2 : 7'(n);
      ACK_memVal   = (ack_mode == 1) ? ack_pat[k % 4] : 1'b1;
    end
    EN_blockRead = 1'b0; ACK_memVal = 1'b1;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL block_timeout: n=%0d got no DONE within %0d cycles", n, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; EN_blockRead = 1'b0; num_words = '0; ACK_memVal = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", RDY_blockRead, 1'b1);
    chk("rst_done", DONE_blockRead, 1'b0);
    chk("rst_en_rd", EN_readMem, 1'b0);
    chk("rst_addr", readMem_addr, 6'd0);
    chk("rst_vld", VALID_memVal, 1'b0);
    chk("rst_dat", memVal_data, 32'h0);

    // 64 words, ack held: valid cycles 3..66, done at 67
    step(); run_block(64, 0, -1, 200);
    chk("t1_first_valid", first_valid, 3);
    chk("t1_last_valid", last_valid, 66);
    chk("t1_done_cycle", done_rel, 67);
    chk("t1_reads", rd_cnt, 64);
    chk("t1_first_data", first_data, 32'h1000_00FF);
    chk("t1_last_data", last_data, 32'h1000_3FC0);

    // 5 words with stalling consumer
    step(); run_block(5, 1, -1, 100);
    chk("t2_words", popped, 5);
    chk("t2_reads", rd_cnt, 5);
    chk("t2_last_data", last_data, 32'h1000_04FB);

    // zero-length request
    step(); run_block(0, 0, -1, 20);
    chk("t3_done_cycle", done_rel, 1);
    chk("t3_reads", rd_cnt, 0);
    chk("t3_rdy_at_done", rdy_at_done, 1'b1);

    // clamp 100 -> 64
    step(); run_block(100, 0, -1, 200);
    chk("t4_reads", rd_cnt, 64);
    chk("t4_last_addr", last_addr, 63);
    chk("t4_words", popped, 64);
    chk("t4_done_cycle", done_rel, 67);

    // reset in cycle 10 of a 64-word block
    step();
    blk_done = 0;
    EN_blockRead = 1'b1; num_words = 7'd64; ACK_memVal = 1'b1;
    for (int k = 1; k <= 10; k++) begin step(); EN_blockRead = 1'b0; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rdy", RDY_blockRead, 1'b1);
    chk("t5_done", DONE_blockRead, 1'b0);
    chk("t5_en_rd", EN_readMem, 1'b0);
    chk("t5_addr", readMem_addr, 6'd0);
    chk("t5_vld", VALID_memVal, 1'b0);
    chk("t5_dat", memVal_data, 32'h0);
    chk("t5_no_done_seen", blk_done, 1'b0);
    step(); run_block(3, 0, -1, 50);
    chk("t5_reads", rd_cnt, 3);
    chk("t5_last_addr", last_addr, 2);
    chk("t5_words", popped, 3);

    // re-pulse mid-block is ignored
    step(); run_block(8, 0, 3, 100);
    chk("t6_reads", rd_cnt, 8);
    chk("t6_words", popped, 8);
    chk("t6_done_cycle", done_rel, 11);
    chk("t6_last_data", last_data, 32'h1000_07F8);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
